// File: rtl/bcd_refresh_sequencer.sv
// Periodic binary-to-BCD refresh controller.
// A divider tick samples bin_in and runs an iterative double-dabble conversion.
module bcd_refresh_sequencer #(
    parameter int DIV    = 500_000,
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  freeze,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  tick,
    output logic                  overrun
);

    localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int IW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;

    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [IW-1:0] LAST_C = IW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADJ   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [IW-1:0] iter;
    logic [SW-1:0] scratch;
    logic [SW-1:0] adj;
    logic [SW-1:0] shifted;
    logic          last_shift;

    // Free-running divider; tick is high the cycle after count hits DIV.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == DIV_C) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CW'(1);
            tick  <= 1'b0;
        end
    end

    // Add-3 correction on every BCD nibble independently, plus the shifted form.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[WIDTH+4*d +: 4] >= 4'd5) begin
                adj[WIDTH+4*d +: 4] = scratch[WIDTH+4*d +: 4] + 4'd3;
            end
        end
        shifted    = {scratch[SW-2:0], 1'b0};
        last_shift = (iter == LAST_C);
    end

    // Conversion FSM: alternate ADJ/SHIFT WIDTH times, publish on final shift.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            iter      <= '0;
            scratch   <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick && !freeze) begin
                        scratch <= {{BW{1'b0}}, bin_in};
                        iter    <= '0;
                        state   <= S_ADJ;
                    end
                end
                S_ADJ: begin
                    scratch <= adj;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    scratch <= shifted;
                    iter    <= iter + IW'(1);
                    if (last_shift) begin
                        state     <= S_IDLE;
                        bcd_out   <= shifted[SW-1 -: BW];
                        bcd_valid <= 1'b1;
                    end else begin
                        state <= S_ADJ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign overrun = tick && busy;

endmodule

// File: tb/tb_bcd_refresh_sequencer.sv
// Directed self-checking bench for bcd_refresh_sequencer.
// Main instance uses DIV=40; a second instance uses DIV=10 to force overruns.
module tb_bcd_refresh_sequencer;

    logic        clk_in;
    logic        rst_n;
    logic [7:0]  bin_in;
    logic        freeze;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic        tick;
    logic        overrun;

    logic [7:0]  bin2;
    logic        freeze2;
    logic [11:0] o_bcd;
    logic        o_valid;
    logic        o_busy;
    logic        o_tick;
    logic        o_overrun;

    int tests = 0;
    int fails = 0;

    bcd_refresh_sequencer #(.DIV(40), .WIDTH(8), .DIGITS(3)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .freeze   (freeze),
        .bcd_out  (bcd_out),
        .bcd_valid(bcd_valid),
        .busy     (busy),
        .tick     (tick),
        .overrun  (overrun)
    );

    bcd_refresh_sequencer #(.DIV(10), .WIDTH(8), .DIGITS(3)) dut_ov (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .bin_in   (bin2),
        .freeze   (freeze2),
        .bcd_out  (o_bcd),
        .bcd_valid(o_valid),
        .busy     (o_busy),
        .tick     (o_tick),
        .overrun  (o_overrun)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in);
            #1;
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL tick_timeout: no tick within 100 cycles, required one");
        end
    endtask

    task automatic run_conv(input logic [7:0] v, output logic [11:0] res,
                            output int lat, output int bsy, output bit ok);
        bit got;
        bin_in = v;
        res = '0;
        lat = 0;
        bsy = 0;
        wait_tick(got);
        ok = 1'b0;
        if (!got) return;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #1;
            lat++;
            if (busy) bsy++;
            if (bcd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        res = bcd_out;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: no bcd_valid for bin=%0d", v);
        end
    endtask

    task automatic test_reset_release();
        int n;
        bit got;
        rst_n = 1'b0;
        freeze = 1'b0;
        freeze2 = 1'b0;
        bin_in = 8'd0;
        bin2 = 8'd99;
        repeat (3) @(posedge clk_in);
        #1;
        tests++;
        if ({bcd_out, bcd_valid, busy, tick, overrun} !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0",
                     {bcd_out, bcd_valid, busy, tick, overrun});
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in);
            #1;
            n++;
            if (tick) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got || n != 41) begin
            fails++;
            $display("FAIL first_tick: got edge %0d (seen=%0d) required 41", n, got);
        end
    endtask

    task automatic test_convert();
        logic [11:0] r;
        int lat;
        int bsy;
        bit ok;
        run_conv(8'd255, r, lat, bsy, ok);
        if (ok) begin
            tests++;
            if (r !== 12'h255) begin
                fails++;
                $display("FAIL conv_255: got %h required 255", r);
            end
            tests++;
            if (lat != 17) begin
                fails++;
                $display("FAIL conv_latency: got %0d required 17", lat);
            end
            tests++;
            if (bsy != 16) begin
                fails++;
                $display("FAIL conv_busy_len: got %0d required 16", bsy);
            end
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL busy_fall: got %b required 0 with valid", busy);
            end
            @(posedge clk_in);
            #1;
            tests++;
            if (bcd_valid !== 1'b0 || bcd_out !== 12'h255) begin
                fails++;
                $display("FAIL valid_pulse: got valid=%b out=%h required 0/255",
                         bcd_valid, bcd_out);
            end
        end
    endtask

    task automatic test_values();
        logic [7:0]  vin [4]  = '{8'd0, 8'd9, 8'd10, 8'd128};
        logic [11:0] vexp [4] = '{12'h000, 12'h009, 12'h010, 12'h128};
        logic [11:0] r;
        logic [11:0] e;
        int lat;
        int bsy;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            run_conv(vin[k], r, lat, bsy, ok);
            if (ok) begin
                tests++;
                if (r !== vexp[k]) begin
                    fails++;
                    $display("FAIL value_%0d: got %h required %h", vin[k], r, vexp[k]);
                end
            end
        end
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), r, lat, bsy, ok);
            e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            if (ok) begin
                tests++;
                if (r !== e) begin
                    fails++;
                    $display("FAIL sweep_%0d: got %h required %h", v, r, e);
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [11:0] r;
        int lat;
        int bsy;
        bit ok;
        int ticks;
        bit seen_busy;
        bit seen_valid;
        run_conv(8'd42, r, lat, bsy, ok);
        if (ok) begin
            tests++;
            if (r !== 12'h042) begin
                fails++;
                $display("FAIL freeze_pre: got %h required 042", r);
            end
        end
        freeze = 1'b1;
        ticks = 0;
        seen_busy = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 200 && ticks < 3; i++) begin
            @(posedge clk_in);
            #1;
            if (tick) begin
                ticks++;
                bin_in = bin_in + 8'd37;
            end
            if (busy) seen_busy = 1'b1;
            if (bcd_valid) seen_valid = 1'b1;
        end
        repeat (3) begin
            @(posedge clk_in);
            #1;
            if (busy) seen_busy = 1'b1;
            if (bcd_valid) seen_valid = 1'b1;
        end
        tests++;
        if (ticks != 3) begin
            fails++;
            $display("FAIL freeze_ticks: got %0d required 3", ticks);
        end
        tests++;
        if (seen_busy || seen_valid) begin
            fails++;
            $display("FAIL freeze_idle: got busy=%b valid=%b required 0/0",
                     seen_busy, seen_valid);
        end
        tests++;
        if (bcd_out !== 12'h042) begin
            fails++;
            $display("FAIL freeze_hold: got %h required 042", bcd_out);
        end
        freeze = 1'b0;
        run_conv(8'd77, r, lat, bsy, ok);
        if (ok) begin
            tests++;
            if (r !== 12'h077) begin
                fails++;
                $display("FAIL unfreeze_conv: got %h required 077", r);
            end
        end
    endtask

    task automatic test_stability();
        bit ok;
        bit got;
        int lat;
        bin_in = 8'd173;
        wait_tick(ok);
        if (ok) begin
            got = 1'b0;
            lat = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk_in);
                #1;
                lat++;
                if (bcd_valid) begin
                    got = 1'b1;
                    break;
                end
                bin_in = ~bin_in;
            end
            tests++;
            if (!got || bcd_out !== 12'h173 || lat != 17) begin
                fails++;
                $display("FAIL stability: got %h lat %0d required 173 lat 17",
                         bcd_out, lat);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        bit got;
        bit bad;
        int n;
        int lat;
        int bsy;
        logic [11:0] r;
        bin_in = 8'd99;
        wait_tick(ok);
        if (!ok) return;
        repeat (6) @(posedge clk_in);
        #1;
        tests++;
        if (busy !== 1'b1 || bcd_out !== 12'h173) begin
            fails++;
            $display("FAIL midrun_busy: got busy=%b out=%h required 1/173",
                     busy, bcd_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bcd_out, bcd_valid, busy, tick, overrun} !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: got %h required 0",
                     {bcd_out, bcd_valid, busy, tick, overrun});
        end
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        n = 0;
        got = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in);
            #1;
            n++;
            if (bcd_valid || bcd_out !== 12'h0 || busy) bad = 1'b1;
            if (tick) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got || n != 41 || bad) begin
            fails++;
            $display("FAIL reset_restart: got edge %0d bad=%b required 41/0", n, bad);
        end
        run_conv(8'd99, r, lat, bsy, ok);
        if (ok) begin
            tests++;
            if (r !== 12'h099) begin
                fails++;
                $display("FAIL post_reset_conv: got %h required 099", r);
            end
        end
    endtask

    task automatic test_overrun();
        bit got;
        bit done;
        bit stray;
        int lat;
        int ov_cnt;
        int ov_at;
        bin2 = 8'd99;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_in);
            #1;
            if (o_tick && !o_busy) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL ov_tick: got none required accepted tick");
            return;
        end
        lat = 0;
        ov_cnt = 0;
        ov_at = 0;
        done = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #1;
            lat++;
            bin2 = 8'd33;
            if (o_overrun) begin
                ov_cnt++;
                ov_at = lat;
                if (!o_tick) stray = 1'b1;
            end
            if (o_valid) begin
                done = 1'b1;
                break;
            end
        end
        tests++;
        if (ov_cnt != 1 || ov_at != 11 || stray) begin
            fails++;
            $display("FAIL ov_pulse: got cnt=%0d at=%0d stray=%b required 1/11/0",
                     ov_cnt, ov_at, stray);
        end
        tests++;
        if (!done || lat != 17 || o_bcd !== 12'h099) begin
            fails++;
            $display("FAIL ov_result: got %h lat %0d required 099 lat 17", o_bcd, lat);
        end
    endtask

    initial begin
        test_reset_release();
        test_convert();
        test_values();
        test_freeze();
        test_stability();
        test_reset_midrun();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
